// File: rtl/bec_uart_pkg.sv
// Shared types and defaults for the byte-oriented UART transmitter.
package bec_uart_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int DIV_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/bec_sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy level and registered ready.
module bec_sync_fifo
   import bec_uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [W-1:0]               i_data,
   input  logic                       i_pop,
   output logic [W-1:0]               o_data,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic          r_ready;
   logic          w_push_ok;
   logic          w_pop_ok;
   logic [LW-1:0] w_level_nxt;

   // A full FIFO refuses pushes even when a pop happens in the same cycle.
   assign w_push_ok = i_push && (r_level != FULL);
   assign w_pop_ok  = i_pop && (r_level != {LW{1'b0}});

   // Next occupancy: simultaneous push and pop leave the level unchanged.
   always_comb begin
      w_level_nxt = r_level;
      if (w_push_ok && !w_pop_ok) begin
         w_level_nxt = r_level + LW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
         w_level_nxt = r_level - LW'(1);
      end else begin
         w_level_nxt = r_level;
      end
   end

   // Pointers (wrap naturally modulo DEPTH), level and ready flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_level <= {LW{1'b0}};
         r_ready <= 1'b1;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + AW'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
         r_level <= w_level_nxt;
         r_ready <= (w_level_nxt != FULL);
      end
   end

   // Byte storage; contents are meaningless once the level is cleared.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= i_data;
   end

   assign o_data  = r_mem[r_rptr];
   assign o_level = r_level;
   assign o_ready = r_ready;

endmodule

// File: rtl/bec_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO, with per-frame latched divisor.
module bec_uart_tx
   import bec_uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   en_i,
   input  logic [DIV_W-1:0]       div_i,
   input  logic [7:0]             data_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   output logic                   tx_o,
   output logic                   busy_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int LW = $clog2(DEPTH) + 1;

   uart_state_t      r_state;
   uart_state_t      w_state_nxt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_baud;
   logic [DIV_W-1:0] w_baud_nxt;
   logic [2:0]       r_bit;
   logic [2:0]       w_bit_nxt;
   logic [7:0]       r_shift;
   logic             r_tx;
   logic             r_busy;
   logic             w_tx_nxt;
   logic             w_pop;
   logic             w_bit_end;
   logic             w_has_data;
   logic [7:0]       w_head;
   logic [LW-1:0]    w_level;
   logic             w_ready;

   bec_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (8)
   ) u_fifo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .i_push  (valid_i),
      .i_data  (data_i),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_level (w_level),
      .o_ready (w_ready)
   );

   assign w_has_data = (w_level != {LW{1'b0}}) && en_i;
   assign w_bit_end  = (r_baud == r_div);

   // Next-state, pop request and baud/bit counter updates.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      case (r_state)
         ST_IDLE: begin
            if (w_has_data) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_START;
               w_baud_nxt  = {DIV_W{1'b0}};
               w_bit_nxt   = 3'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               w_state_nxt = ST_DATA;
               w_baud_nxt  = {DIV_W{1'b0}};
               w_bit_nxt   = 3'd0;
            end else begin
               w_baud_nxt  = r_baud + DIV_W'(1);
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_baud_nxt = {DIV_W{1'b0}};
               if (r_bit == 3'd7) begin
                  w_state_nxt = ST_STOP;
                  w_bit_nxt   = 3'd0;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud + DIV_W'(1);
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               w_baud_nxt = {DIV_W{1'b0}};
               w_bit_nxt  = 3'd0;
               if (w_has_data) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_START;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_baud_nxt = r_baud + DIV_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_baud_nxt  = {DIV_W{1'b0}};
            w_bit_nxt   = 3'd0;
         end
      endcase
   end

   // Line level for the upcoming cycle, so tx_o can be a plain register.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         ST_START: w_tx_nxt = 1'b0;
         ST_DATA:  w_tx_nxt = r_shift[w_bit_nxt];
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   // FSM state, counters and per-frame latches (byte and divisor taken at pop).
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_baud  <= {DIV_W{1'b0}};
         r_bit   <= 3'd0;
         r_div   <= {DIV_W{1'b0}};
         r_shift <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         if (w_pop) begin
            r_div   <= div_i;
            r_shift <= w_head;
         end
      end
   end

   // Registered line and busy outputs; reset drives the line high at once.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_tx   <= 1'b1;
         r_busy <= 1'b0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_busy <= (w_state_nxt != ST_IDLE);
      end
   end

   assign tx_o    = r_tx;
   assign busy_o  = r_busy;
   assign ready_o = w_ready;
   assign level_o = w_level;

endmodule

// File: tb/tb_bec_uart_tx.sv
// Scoreboard bench: stimulus queues expected frames, a line receiver decodes and checks them.
module tb_bec_uart_tx;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        en_i     = 1'b0;
   logic [15:0] div_i    = 16'd0;
   logic [7:0]  data_i   = 8'h00;
   logic        valid_i  = 1'b0;
   logic        ready_o;
   logic        tx_o;
   logic        busy_o;
   logic [2:0]  level_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] data;
      int         div;
   } exp_t;

   exp_t exp_q[$];
   exp_t rx_e;
   bit   rx_active = 1'b0;
   int   rx_cnt, rx_total, rx_err, rx_busy_err, rx_idx, rx_pos;
   logic       rx_lvl;
   logic [7:0] rx_byte;

   bec_uart_tx #(.DEPTH(4), .DIV_W(16)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .en_i     (en_i),
      .div_i    (div_i),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .tx_o     (tx_o),
      .busy_o   (busy_o),
      .level_o  (level_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string nm, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Line receiver: samples every cycle, knows the expected divisor of each frame.
   always @(negedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_active = 1'b0;
         exp_q.delete();
      end else begin
         if (!rx_active && tx_o == 1'b0) begin
            if (exp_q.size() == 0) begin
               check("rx_unexpected_frame", 1, 0);
            end else begin
               rx_e        = exp_q.pop_front();
               rx_active   = 1'b1;
               rx_cnt      = 0;
               rx_total    = 10 * (rx_e.div + 1);
               rx_err      = 0;
               rx_busy_err = 0;
               rx_byte     = 8'h00;
            end
         end
         if (rx_active) begin
            rx_idx = rx_cnt / (rx_e.div + 1);
            rx_pos = rx_cnt % (rx_e.div + 1);
            if (rx_idx == 0)      rx_lvl = 1'b0;
            else if (rx_idx == 9) rx_lvl = 1'b1;
            else                  rx_lvl = rx_e.data[rx_idx-1];
            if (tx_o !== rx_lvl) rx_err++;
            if (busy_o !== 1'b1) rx_busy_err++;
            if (rx_idx >= 1 && rx_idx <= 8 && rx_pos == rx_e.div / 2)
               rx_byte[rx_idx-1] = tx_o;
            rx_cnt++;
            if (rx_cnt == rx_total) begin
               check("rx_byte", int'(rx_byte), int'(rx_e.data));
               check("rx_framing_errors", rx_err, 0);
               check("rx_busy_low_in_frame", rx_busy_err, 0);
               rx_active = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Offer one byte, wait (bounded) for acceptance, record the expected frame.
   task automatic push(input logic [7:0] b);
      int g = 0;
      exp_t e;
      data_i  = b;
      valid_i = 1'b1;
      while (!ready_o && g < 2000) begin
         tick();
         g++;
      end
      check("push_accept_timeout", int'(g < 2000), 1);
      e.data = b;
      e.div  = int'(div_i);
      exp_q.push_back(e);
      tick();
      valid_i = 1'b0;
   endtask

   task automatic drain(input string nm);
      int g = 0;
      while ((exp_q.size() != 0 || rx_active || busy_o) && g < 5000) begin
         tick();
         g++;
      end
      check({nm, "_drain_timeout"}, int'(g < 5000), 1);
   endtask

   initial begin
      int busy_cnt, first, last, accepted, low_cnt;
      exp_t e;

      // Reset state while reset is held.
      repeat (3) tick();
      check("rst_tx", int'(tx_o), 1);
      check("rst_busy", int'(busy_o), 0);
      check("rst_level", int'(level_o), 0);
      check("rst_ready", int'(ready_o), 1);
      wb_rst_i = 1'b0;
      tick();

      // Single byte at div 3: 40-clock frame, busy exactly 40 clocks.
      en_i  = 1'b1;
      div_i = 16'd3;
      push(8'hA5);
      busy_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge wb_clk_i);
         if (busy_o) busy_cnt++;
      end
      check("single_busy_clocks", busy_cnt, 40);
      drain("single");

      // Back-to-back: fill with en low, then four contiguous frames.
      en_i  = 1'b0;
      div_i = 16'd0;
      push(8'h55);
      push(8'h0F);
      push(8'hF0);
      push(8'h00);
      check("b2b_ready_full", int'(ready_o), 0);
      check("b2b_level_full", int'(level_o), 4);
      en_i  = 1'b1;
      first = -1;
      last  = -1;
      busy_cnt = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge wb_clk_i);
         if (busy_o) begin
            busy_cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      check("b2b_busy_clocks", busy_cnt, 40);
      check("b2b_busy_span", last - first + 1, 40);
      drain("b2b");

      // Full FIFO: six offered bytes with en low, only four taken.
      en_i     = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         data_i  = 8'(i + 1);
         valid_i = 1'b1;
         if (ready_o) begin
            e.data = 8'(i + 1);
            e.div  = 0;
            exp_q.push_back(e);
            accepted++;
         end
         tick();
      end
      valid_i = 1'b0;
      check("full_accepted", accepted, 4);
      check("full_level", int'(level_o), 4);
      check("full_ready", int'(ready_o), 0);
      check("full_tx_idle", int'(tx_o), 1);
      en_i = 1'b1;
      drain("full");

      // Enable/divisor change mid-frame: current frame keeps div 1.
      div_i = 16'd1;
      push(8'h3C);
      repeat (6) tick();
      en_i  = 1'b0;
      div_i = 16'd7;
      push(8'hC6);
      repeat (40) tick();
      check("endis_idle_busy", int'(busy_o), 0);
      check("endis_idle_level", int'(level_o), 1);
      check("endis_idle_tx", int'(tx_o), 1);
      en_i = 1'b1;
      drain("endis");

      // Randomised batches, one divisor per batch.
      for (int b = 0; b < 3; b++) begin
         div_i = 16'($urandom_range(0, 5));
         for (int k = 0; k < 6; k++) begin
            push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) tick();
         end
         drain("rand");
      end

      // Reset during bit 3 with bytes still queued.
      en_i  = 1'b0;
      div_i = 16'd3;
      push(8'hF0);
      push(8'h33);
      push(8'h44);
      en_i = 1'b1;
      repeat (18) tick();
      check("rstmid_tx_before", int'(tx_o), 0);
      check("rstmid_level_before", int'(level_o), 2);
      wb_rst_i = 1'b1;
      #1;
      check("rstmid_tx_async", int'(tx_o), 1);
      check("rstmid_level", int'(level_o), 0);
      check("rstmid_busy", int'(busy_o), 0);
      tick();
      wb_rst_i = 1'b0;
      low_cnt  = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge wb_clk_i);
         if (!tx_o) low_cnt++;
      end
      check("rstmid_no_frames", low_cnt, 0);
      check("end_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
